// File: rtl/ras_checker.sv
// Return-address-stack prediction checker: tracks in-flight RAS predictions and flags wrong/missing targets.
// Optional hit/miss statistics are enabled with `define RAS_CHECKER_STATS_EN.
module ras_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 31
) (
  input  logic                     s_clk_i,
  input  logic                     s_reset_i,
  input  logic                     s_flush_i,
  input  logic                     s_pred_valid_i,
  input  logic [WIDTH-1:0]         s_pred_addr_i,
  input  logic                     s_res_valid_i,
  input  logic                     s_res_pred_i,
  input  logic [WIDTH-1:0]         s_res_target_i,
  output logic                     s_mispredict_o,
  output logic [WIDTH-1:0]         s_redirect_addr_o,
  output logic                     s_invalidate_o,
`ifdef RAS_CHECKER_STATS_EN
  output logic [15:0]              s_hits_o,
  output logic [15:0]              s_misses_o,
`endif
  output logic [$clog2(DEPTH):0]   s_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count, count_n;

  logic do_check, full, empty, head_match;
  logic clear, enq, deq, mis_n, inv_n;

  assign do_check   = s_res_valid_i & s_res_pred_i;
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign head_match = (mem[rptr] == s_res_target_i);

  // Per-cycle decision; flush dominates, then overflow, then the check result.
  // A push into a full FIFO alongside a predicted resolve is handled as a simultaneous enq/deq.
  always_comb begin
    clear = 1'b0;
    enq   = 1'b0;
    deq   = 1'b0;
    mis_n = 1'b0;
    inv_n = 1'b0;
    if (s_flush_i) begin
      clear = 1'b1;
    end else if (s_pred_valid_i && full && !do_check) begin
      clear = 1'b1;
      inv_n = 1'b1;
    end else if (do_check && (empty || !head_match)) begin
      clear = 1'b1;
      mis_n = 1'b1;
      inv_n = 1'b1;
    end else begin
      deq = do_check;
      enq = s_pred_valid_i && (!full || do_check);
    end
  end

  always_comb begin
    count_n = count;
    if (clear) count_n = '0;
    else       count_n = count + CNT_W'(enq) - CNT_W'(deq);
  end

  // Pointer and occupancy state
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      count <= count_n;
      if (clear) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (enq) wptr <= wptr + PTR_W'(1);
        if (deq) rptr <= rptr + PTR_W'(1);
      end
    end
  end

  // Prediction storage; contents are don't-care while not counted
  always_ff @(posedge s_clk_i) begin
    if (enq) mem[wptr] <= s_pred_addr_i;
  end

  // Registered one-cycle pulses and the corrected target
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      s_mispredict_o    <= 1'b0;
      s_invalidate_o    <= 1'b0;
      s_redirect_addr_o <= '0;
    end else begin
      s_mispredict_o <= mis_n;
      s_invalidate_o <= inv_n;
      if (mis_n) s_redirect_addr_o <= s_res_target_i;
    end
  end

  assign s_count_o = count;

`ifdef RAS_CHECKER_STATS_EN
  // Saturating statistics, cleared only by reset
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      s_hits_o   <= '0;
      s_misses_o <= '0;
    end else begin
      if (deq && s_hits_o != 16'hFFFF)     s_hits_o   <= s_hits_o + 16'd1;
      if (inv_n && s_misses_o != 16'hFFFF) s_misses_o <= s_misses_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ras_checker.sv
// Scoreboard bench for ras_checker: stimulus pushes expected pulses, a negedge monitor pops and compares.
module tb_ras_checker;

  localparam int unsigned W = 31;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, pv, rv, rp;
  logic [W-1:0]  pa, rt;
  logic          mis, inv;
  logic [W-1:0]  redir;
  logic [2:0]    cnt;
`ifdef RAS_CHECKER_STATS_EN
  logic [15:0]   hits, misses;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic         mis;
    logic         inv;
    logic [W-1:0] redir;
    int           cyc;
  } exp_t;

  exp_t expq[$];

  ras_checker #(.DEPTH(4), .WIDTH(W)) dut (
    .s_clk_i           (clk),
    .s_reset_i         (rst),
    .s_flush_i         (flush),
    .s_pred_valid_i    (pv),
    .s_pred_addr_i     (pa),
    .s_res_valid_i     (rv),
    .s_res_pred_i      (rp),
    .s_res_target_i    (rt),
    .s_mispredict_o    (mis),
    .s_redirect_addr_o (redir),
    .s_invalidate_o    (inv),
`ifdef RAS_CHECKER_STATS_EN
    .s_hits_o          (hits),
    .s_misses_o        (misses),
`endif
    .s_count_o         (cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse seen must match the oldest expectation, in the right cycle
  always @(negedge clk) begin
    if (!rst && (mis || inv)) begin
      if (expq.size() == 0) begin
        check("unexpected_pulse", {30'd0, mis, inv}, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("mispredict", {31'd0, mis}, {31'd0, e.mis});
        check("invalidate", {31'd0, inv}, {31'd0, e.inv});
        if (e.mis) check("redirect", {1'b0, redir}, {1'b0, e.redir});
      end
    end
  end

  // One clock of stimulus; inputs change just after the rising edge
  task automatic step(input logic f, input logic p_v, input logic [W-1:0] p_a,
                      input logic r_v, input logic r_p, input logic [W-1:0] r_t,
                      input logic e_mis, input logic e_inv);
    exp_t e;
    flush = f; pv = p_v; pa = p_a; rv = r_v; rp = r_p; rt = r_t;
    if (e_mis || e_inv) begin
      e.mis = e_mis; e.inv = e_inv; e.redir = r_t; e.cyc = cyc + 1;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    flush = 1'b0; pv = 1'b0; rv = 1'b0; rp = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] a);
    step(1'b0, 1'b1, a, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic [W-1:0] t, input logic e_mis);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, t, e_mis, e_mis);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0; pv = 1'b0; rv = 1'b0; rp = 1'b0; pa = '0; rt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("reset_count", {29'd0, cnt}, 32'd0);
    check("reset_mis", {31'd0, mis}, 32'd0);
    check("reset_inv", {31'd0, inv}, 32'd0);
    check("reset_redir", {1'b0, redir}, 32'd0);

    // Two matching predictions
    push(31'h100);  check("cnt_push1", {29'd0, cnt}, 32'd1);
    push(31'h200);  check("cnt_push2", {29'd0, cnt}, 32'd2);
    resolve(31'h100, 1'b0); check("cnt_res1", {29'd0, cnt}, 32'd1);
    resolve(31'h200, 1'b0); check("cnt_res2", {29'd0, cnt}, 32'd0);

    // Wrong target
    push(31'h100);
    resolve(31'h104, 1'b1); check("cnt_mismatch", {29'd0, cnt}, 32'd0);
    idle(1);

    // Resolve with nothing tracked
    resolve(31'h40, 1'b1); check("cnt_empty_res", {29'd0, cnt}, 32'd0);
    idle(1);

    // Overflow: fifth push invalidates only
    push(31'h10); push(31'h20); push(31'h30); push(31'h40);
    check("cnt_full", {29'd0, cnt}, 32'd4);
    step(1'b0, 1'b1, 31'h50, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("cnt_overflow", {29'd0, cnt}, 32'd0);
    idle(1);

    // Simultaneous push + matching resolve, then flush with both
    push(31'hA0); push(31'hB0);
    step(1'b0, 1'b1, 31'hC0, 1'b1, 1'b1, 31'hA0, 1'b0, 1'b0);
    check("cnt_simul", {29'd0, cnt}, 32'd2);
    step(1'b1, 1'b1, 31'hD0, 1'b1, 1'b1, 31'hBAD, 1'b0, 1'b0);
    check("cnt_flush", {29'd0, cnt}, 32'd0);
    idle(1);

    // Unpredicted return leaves tracking untouched
    push(31'h300);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 31'h999, 1'b0, 1'b0);
    check("cnt_unpred", {29'd0, cnt}, 32'd1);
    resolve(31'h300, 1'b0); check("cnt_after_unpred", {29'd0, cnt}, 32'd0);

    // Mismatch with same-cycle push clears everything; following flush keeps the pulse
    push(31'h400); push(31'h500);
    step(1'b0, 1'b1, 31'h600, 1'b1, 1'b1, 31'h404, 1'b1, 1'b1);
    check("cnt_mis_push", {29'd0, cnt}, 32'd0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(1);

    // Asynchronous reset mid-operation
    push(31'h700); push(31'h800);
    rst = 1'b1;
    #1;
    check("async_rst_cnt", {29'd0, cnt}, 32'd0);
    check("async_rst_mis", {31'd0, mis}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

`ifdef RAS_CHECKER_STATS_EN
    do_reset();
    check("stats_reset_hits", {16'd0, hits}, 32'd0);
    push(31'h1); push(31'h2); push(31'h3); push(31'h4);
    resolve(31'h1, 1'b0); resolve(31'h2, 1'b0); resolve(31'h3, 1'b0);
    resolve(31'h5, 1'b1);
    idle(1);
    check("stats_hits", {16'd0, hits}, 32'd3);
    check("stats_misses", {16'd0, misses}, 32'd1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("stats_flush_hits", {16'd0, hits}, 32'd3);
    check("stats_flush_misses", {16'd0, misses}, 32'd1);
    do_reset();
    check("stats_rst_hits", {16'd0, hits}, 32'd0);
    check("stats_rst_misses", {16'd0, misses}, 32'd0);
`endif

    idle(3);
    check("pending_expectations", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
